// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity serial transmitter: FSM encoding and line levels.
package parity_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/even_parity_serial_tx_baud.sv
// Bit-period timer: tick is high on the last clk cycle of each serial bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // clear realigns the period to the accept edge so START lasts a full bit time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: valid/ready word in, start/data(LSB first)/parity/stop frame out.
module even_parity_serial_tx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              parity_out,
    output logic              busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_tx;
    logic              r_parity;

    logic              w_accept;
    logic              w_tick;
    logic [DATA_W-1:0] w_shift_next;

    assign w_accept     = data_valid && (r_state == IDLE);
    assign w_shift_next = r_shift >> 1;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= IDLE_LEVEL;
            r_parity  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (data_valid) begin
                        r_shift   <= data_in;
                        r_parity  <= ^data_in;
                        r_bit_idx <= '0;
                        r_tx      <= START_BIT;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    // tx is loaded with the next bit on the same edge the shift happens
                    if (w_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_tx    <= r_parity;
                            r_state <= PARITY;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= STOP_BIT;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_tx     <= IDLE_LEVEL;
                        r_parity <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign tx_out     = r_tx;
    assign parity_out = r_parity;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench for even_parity_serial_tx: directed table, reset cases, random frames.
module tb_even_parity_serial_tx;

    localparam int DW   = 8;
    localparam int CPB  = 4;
    localparam int NB   = DW + 3;
    localparam int FLEN = NB * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready, tx_out, parity_out, busy;

    logic          d1_in, d1_valid;
    logic          d1_ready, d1_tx, d1_par, d1_busy;

    int checks = 0;
    int errors = 0;

    even_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx_out(tx_out), .parity_out(parity_out), .busy(busy)
    );

    even_parity_serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1_in), .data_valid(d1_valid),
        .data_ready(d1_ready), .tx_out(d1_tx), .parity_out(d1_par), .busy(d1_busy)
    );

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic [10:0] line;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as line bits in transmit order (bit 0 = start), from the framing rules.
    function automatic logic [10:0] model_line(input logic [7:0] d);
        logic [10:0] l;
        int ones;
        ones = 0;
        l = '0;
        for (int i = 0; i < DW; i++) ones += int'((d >> i) & 8'd1);
        for (int k = 0; k < NB; k++) begin
            if (k == 0)            l[k] = 1'b0;
            else if (k <= DW)      l[k] = (((d >> (k - 1)) & 8'd1) != 8'd0);
            else if (k == DW + 1)  l[k] = ((ones % 2) == 1);
            else                   l[k] = 1'b1;
        end
        return l;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [10:0] exp_line, input logic exp_par,
                              input bit hold, input logic [7:0] next_d, input string tag);
        int t, k, unstable, busy_cnt, par_bad;
        logic [10:0] cap;
        t = 0; unstable = 0; busy_cnt = 0; par_bad = 0; cap = '0;
        while (!data_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, " ready_before"}, 32'(data_ready), 32'd1);
        data_in    = d;
        data_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= FLEN; n++) begin
            @(negedge clk);
            if (!hold) data_valid = 1'b0;
            data_in = (n == FLEN) ? next_d : 8'($urandom);
            k = (n - 1) / CPB;
            if ((n - 1) % CPB == 0) cap[k] = tx_out;
            else if (tx_out !== cap[k]) unstable++;
            if (busy === 1'b1) busy_cnt++;
            if (parity_out !== exp_par) par_bad++;
        end
        check({tag, " line"}, 32'(cap), 32'(exp_line));
        check({tag, " bit_stable"}, 32'(unstable), 32'd0);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(FLEN));
        check({tag, " parity_out"}, 32'(par_bad), 32'd0);
        check({tag, " rx_data"}, 32'(cap[8:1]), 32'(d));
        check({tag, " rx_even_parity"}, 32'(^cap[9:1]), 32'd0);
        @(negedge clk);
        check({tag, " idle_tx"}, 32'(tx_out), 32'd1);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_ready"}, 32'(data_ready), 32'd1);
        check({tag, " idle_parity"}, 32'(parity_out), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_l;
        logic [7:0]  d;
        logic [3:0]  seq;
        int          bcnt;

        tbl[0] = '{8'hA5, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}};
        tbl[1] = '{8'h07, 1'b1, {1'b1, 1'b1, 8'h07, 1'b0}};
        tbl[2] = '{8'h00, 1'b0, {1'b1, 1'b0, 8'h00, 1'b0}};
        tbl[3] = '{8'h80, 1'b1, {1'b1, 1'b1, 8'h80, 1'b0}};
        tbl[4] = '{8'hFF, 1'b0, {1'b1, 1'b0, 8'hFF, 1'b0}};
        tbl[5] = '{8'h3C, 1'b0, {1'b1, 1'b0, 8'h3C, 1'b0}};
        tbl[6] = '{8'h01, 1'b1, {1'b1, 1'b1, 8'h01, 1'b0}};
        tbl[7] = '{8'h6E, 1'b1, {1'b1, 1'b1, 8'h6E, 1'b0}};

        rst = 1'b1; data_in = '0; data_valid = 1'b0; d1_in = 1'b0; d1_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            data_in = 8'($urandom); data_valid = 1'($urandom);
            d1_in = 1'($urandom); d1_valid = 1'($urandom);
        end
        check("rst tx", 32'(tx_out), 32'd1);
        check("rst ready", 32'(data_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst parity", 32'(parity_out), 32'd0);
        check("rst dut1 tx", 32'(d1_tx), 32'd1);
        data_valid = 1'b0; d1_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("post_rst tx", 32'(tx_out), 32'd1);
        check("post_rst ready", 32'(data_ready), 32'd1);
        check("post_rst busy", 32'(busy), 32'd0);
        check("post_rst parity", 32'(parity_out), 32'd0);

        for (int i = 0; i < 8; i++)
            send_frame(tbl[i].data, tbl[i].line, tbl[i].par, 1'b0, 8'h00, $sformatf("tbl%0d", i));

        // Valid held across two frames; second word must go out after one idle cycle.
        send_frame(8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}, 1'b0, 1'b1, 8'hFF, "b2b_3C");
        send_frame(8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 1'b0, 1'b0, 8'h00, "b2b_FF");

        data_in = 8'h81; data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        check("midrst busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst tx", 32'(tx_out), 32'd1);
        check("midrst ready", 32'(data_ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst parity", 32'(parity_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, 1'b1 /*par*/, 1'b0, 8'h00, "after_rst_01");

        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            exp_l = model_line(d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(d, exp_l, exp_l[9], 1'b0, 8'h00, $sformatf("rnd%0d_%02h", i, d));
        end

        for (int v = 0; v < 2; v++) begin
            seq = '0; bcnt = 0;
            @(negedge clk);
            d1_in = (v == 0); d1_valid = 1'b1;
            @(posedge clk);
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                d1_valid = 1'b0;
                seq[n] = d1_tx;
                if (d1_busy === 1'b1) bcnt++;
            end
            check($sformatf("w1_seq_%0d", v), 32'(seq), (v == 0) ? 32'b1110 : 32'b1000);
            check($sformatf("w1_busy_%0d", v), 32'(bcnt), 32'd4);
            @(negedge clk);
            check($sformatf("w1_idle_busy_%0d", v), 32'(d1_busy), 32'd0);
            check($sformatf("w1_idle_tx_%0d", v), 32'(d1_tx), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
